// File: rtl/hp_pkg.sv
// Shared constants and helpers for the host-to-parasite byte quad.
package hp_pkg;

   localparam int unsigned HP_R1       = 0;
   localparam int unsigned HP_R2       = 1;
   localparam int unsigned HP_R3       = 2;
   localparam int unsigned HP_R4       = 3;
   localparam int unsigned HP_NREG     = 4;
   localparam int unsigned HP_R3_DEPTH = 2;

   // Isolates the lowest set bit so multi-hot selects act on one register only.
   function automatic logic [HP_NREG-1:0] hp_lowest(input logic [HP_NREG-1:0] sel);
      return sel & (~sel + {{(HP_NREG-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/hp_bytequad_if.sv
// Host write bus, parasite read bus, mode/enable controls and status of the byte quad.
interface hp_bytequad_if;
   import hp_pkg::*;

   logic               h_we;
   logic [HP_NREG-1:0] h_selectData;
   logic [7:0]         h_data;
   logic               p_rd;
   logic [HP_NREG-1:0] p_selectData;
   logic               one_byte_mode;
   logic               irq_en_r1;
   logic               irq_en_r4;
   logic               nmi_en;
   logic [7:0]         p_data;
   logic [HP_NREG-1:0] p_data_available;
   logic [HP_NREG-1:0] h_full;
   logic               p_irq;
   logic               p_nmi;

   modport master (
      output h_we, h_selectData, h_data, p_rd, p_selectData,
             one_byte_mode, irq_en_r1, irq_en_r4, nmi_en,
      input  p_data, p_data_available, h_full, p_irq, p_nmi
   );

   modport slave (
      input  h_we, h_selectData, h_data, p_rd, p_selectData,
             one_byte_mode, irq_en_r1, irq_en_r4, nmi_en,
      output p_data, p_data_available, h_full, p_irq, p_nmi
   );

endinterface

// File: rtl/hp_reg3_fifo.sv
// Tube R3: two-entry FIFO whose available/full thresholds depend on one_byte_mode.
module hp_reg3_fifo
   import hp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       one_byte_mode,
   input  logic       push_req,
   input  logic [7:0] push_data,
   input  logic       pop_req,
   output logic [7:0] rd_data,
   output logic       avail,
   output logic       full
);

   logic [7:0] mem [HP_R3_DEPTH];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic       mode_q;
   logic       flush;
   logic       push;
   logic       pop;

   always_comb begin
      flush = one_byte_mode != mode_q;
      avail = one_byte_mode ? (count != 2'd0) : (count == 2'(HP_R3_DEPTH));
      full  = avail;
      // Draining is allowed whenever a byte is held, so a two-byte transfer
      // empties completely even though avail drops after the first read.
      pop   = pop_req & (count != 2'd0);
      push  = push_req & (~full | pop) & ~flush;
      rd_data = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < HP_R3_DEPTH; i++) mem[i] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
         mode_q <= one_byte_mode;
      end else begin
         mode_q <= one_byte_mode;
         if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
         end else begin
            if (push) begin
               mem[wr_ptr] <= push_data;
               wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
         end
      end
   end

endmodule

// File: rtl/hp_bytequad.sv
// Host-to-parasite byte quad: R1/R2/R4 single-byte latches, R3 FIFO, parasite IRQ/NMI.
module hp_bytequad
   import hp_pkg::*;
(
   input  logic          h_phi2,
   input  logic          h_rst,
   hp_bytequad_if.slave  bus
);

   logic [HP_NREG-1:0]      wsel;
   logic [HP_NREG-1:0]      rsel_lo;
   logic [HP_NREG-1:0]      rsel;
   logic [HP_NREG-1:0]      avail;
   logic [HP_NREG-1:0]      full;
   logic [HP_NREG-1:0][7:0] rdat;
   logic [7:0]              pdata;

   assign wsel    = hp_lowest(bus.h_selectData) & {HP_NREG{bus.h_we}};
   assign rsel_lo = hp_lowest(bus.p_selectData);
   assign rsel    = rsel_lo & {HP_NREG{bus.p_rd}};

   for (genvar gi = 0; gi < HP_NREG; gi++) begin : g_reg
      if (gi == HP_R3) begin : g_r3
         hp_reg3_fifo u_r3 (
            .clk           (h_phi2),
            .rst           (h_rst),
            .one_byte_mode (bus.one_byte_mode),
            .push_req      (wsel[gi]),
            .push_data     (bus.h_data),
            .pop_req       (rsel[gi]),
            .rd_data       (rdat[gi]),
            .avail         (avail[gi]),
            .full          (full[gi])
         );
      end else begin : g_lat
         logic       valid_q;
         logic [7:0] data_q;
         logic       pop;
         logic       push;

         // A pop in the same cycle frees the slot, so a full latch still takes the new byte.
         assign pop  = rsel[gi] & valid_q;
         assign push = wsel[gi] & (~valid_q | pop);

         always_ff @(posedge h_phi2) begin
            if (h_rst) begin
               valid_q <= 1'b0;
               data_q  <= '0;
            end else if (push) begin
               valid_q <= 1'b1;
               data_q  <= bus.h_data;
            end else if (pop) begin
               valid_q <= 1'b0;
            end
         end

         assign avail[gi] = valid_q;
         assign full[gi]  = valid_q;
         assign rdat[gi]  = data_q;
      end
   end

   always_comb begin
      pdata = '0;
      for (int unsigned i = 0; i < HP_NREG; i++) begin
         if (rsel_lo[i]) pdata = rdat[i];
      end
   end

   assign bus.p_data           = pdata;
   assign bus.p_data_available = avail;
   assign bus.h_full           = full;
   assign bus.p_irq            = (bus.irq_en_r1 & avail[HP_R1]) | (bus.irq_en_r4 & avail[HP_R4]);
   assign bus.p_nmi            = bus.nmi_en & avail[HP_R3];

endmodule

// File: tb/tb_hp_bytequad.sv
// Self-checking bench for hp_bytequad: directed scenarios plus randomized queue-model run.
module tb_hp_bytequad;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   hp_bytequad_if bus();

   hp_bytequad dut (
      .h_phi2 (clk),
      .h_rst  (rst),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mq [4][$];

   function automatic int lowest(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) return i;
      return -1;
   endfunction

   task automatic idle();
      bus.h_we         = 1'b0;
      bus.h_selectData = 4'b0000;
      bus.p_rd         = 1'b0;
      bus.p_selectData = 4'b0000;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int unsigned idx, input logic [7:0] d);
      bus.h_we         = 1'b1;
      bus.h_selectData = 4'(1 << idx);
      bus.h_data       = d;
      tick();
      idle();
   endtask

   task automatic rd(input int unsigned idx, output logic [7:0] d);
      bus.p_rd         = 1'b1;
      bus.p_selectData = 4'(1 << idx);
      @(negedge clk);
      d = bus.p_data;
      tick();
      idle();
   endtask

   task automatic test_reset();
      idle();
      bus.h_data        = 8'hFF;
      bus.one_byte_mode = 1'b0;
      bus.irq_en_r1     = 1'b1;
      bus.irq_en_r4     = 1'b1;
      bus.nmi_en        = 1'b1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (bus.p_data_available !== 4'b0000) begin bad++; $display("FAIL rst_avail got=%b want=0000", bus.p_data_available); end
      total++; if (bus.h_full !== 4'b0000) begin bad++; $display("FAIL rst_full got=%b want=0000", bus.h_full); end
      total++; if (bus.p_irq !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b want=0", bus.p_irq); end
      total++; if (bus.p_nmi !== 1'b0) begin bad++; $display("FAIL rst_nmi got=%b want=0", bus.p_nmi); end
      total++; if (bus.p_data !== 8'h00) begin bad++; $display("FAIL rst_pdata got=%h want=00", bus.p_data); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.irq_en_r1 = 1'b0;
      bus.irq_en_r4 = 1'b0;
      bus.nmi_en    = 1'b0;
   endtask

   task automatic test_r1_irq();
      logic [7:0] d;
      bus.irq_en_r1 = 1'b1;
      wr(0, 8'hA5);
      total++; if (bus.p_data_available[0] !== 1'b1) begin bad++; $display("FAIL r1_avail got=%b want=1", bus.p_data_available[0]); end
      total++; if (bus.h_full[0] !== 1'b1) begin bad++; $display("FAIL r1_full got=%b want=1", bus.h_full[0]); end
      total++; if (bus.p_irq !== 1'b1) begin bad++; $display("FAIL r1_irq_set got=%b want=1", bus.p_irq); end
      rd(0, d);
      total++; if (d !== 8'hA5) begin bad++; $display("FAIL r1_read got=%h want=a5", d); end
      total++; if (bus.p_irq !== 1'b0) begin bad++; $display("FAIL r1_irq_clr got=%b want=0", bus.p_irq); end
      rd(0, d);
      total++; if (d !== 8'hA5) begin bad++; $display("FAIL r1_stale got=%h want=a5", d); end
      total++; if (bus.p_data_available !== 4'b0000) begin bad++; $display("FAIL r1_empty got=%b want=0000", bus.p_data_available); end
      bus.irq_en_r1 = 1'b0;
   endtask

   task automatic test_r3_two_byte();
      logic [7:0] d;
      bus.nmi_en = 1'b1;
      wr(2, 8'h11);
      total++; if (bus.p_nmi !== 1'b0) begin bad++; $display("FAIL r3two_nmi1 got=%b want=0", bus.p_nmi); end
      total++; if (bus.h_full[2] !== 1'b0) begin bad++; $display("FAIL r3two_full1 got=%b want=0", bus.h_full[2]); end
      wr(2, 8'h22);
      total++; if (bus.p_nmi !== 1'b1) begin bad++; $display("FAIL r3two_nmi2 got=%b want=1", bus.p_nmi); end
      total++; if (bus.h_full[2] !== 1'b1) begin bad++; $display("FAIL r3two_full2 got=%b want=1", bus.h_full[2]); end
      rd(2, d);
      total++; if (d !== 8'h11) begin bad++; $display("FAIL r3two_rd1 got=%h want=11", d); end
      rd(2, d);
      total++; if (d !== 8'h22) begin bad++; $display("FAIL r3two_rd2 got=%h want=22", d); end
      total++; if (bus.p_nmi !== 1'b0) begin bad++; $display("FAIL r3two_nmi0 got=%b want=0", bus.p_nmi); end
      // Drained to zero: one more byte must not look like a complete pair.
      wr(2, 8'h5C);
      total++; if (bus.p_data_available[2] !== 1'b0) begin bad++; $display("FAIL r3two_cnt0 got=%b want=0", bus.p_data_available[2]); end
      bus.nmi_en = 1'b0;
   endtask

   task automatic test_r3_one_byte();
      logic [7:0] d;
      bus.nmi_en        = 1'b1;
      bus.one_byte_mode = 1'b1;
      tick();
      wr(2, 8'h33);
      total++; if (bus.h_full[2] !== 1'b1) begin bad++; $display("FAIL r3one_full got=%b want=1", bus.h_full[2]); end
      total++; if (bus.p_nmi !== 1'b1) begin bad++; $display("FAIL r3one_nmi got=%b want=1", bus.p_nmi); end
      wr(2, 8'h44);
      rd(2, d);
      total++; if (d !== 8'h33) begin bad++; $display("FAIL r3one_drop got=%h want=33", d); end
      total++; if (bus.p_data_available[2] !== 1'b0) begin bad++; $display("FAIL r3one_empty got=%b want=0", bus.p_data_available[2]); end
      bus.nmi_en = 1'b0;
   endtask

   task automatic test_collide();
      logic [7:0] d;
      wr(1, 8'h55);
      bus.h_we         = 1'b1;
      bus.h_selectData = 4'b0010;
      bus.h_data       = 8'h66;
      bus.p_rd         = 1'b1;
      bus.p_selectData = 4'b0110;
      @(negedge clk);
      total++; if (bus.p_data !== 8'h55) begin bad++; $display("FAIL col_rd_old got=%h want=55", bus.p_data); end
      tick();
      idle();
      total++; if (bus.p_data_available[1] !== 1'b1) begin bad++; $display("FAIL col_avail got=%b want=1", bus.p_data_available[1]); end
      rd(1, d);
      total++; if (d !== 8'h66) begin bad++; $display("FAIL col_rd_new got=%h want=66", d); end
      wr(3, 8'h88);
      bus.irq_en_r4 = 1'b1;
      #1;
      total++; if (bus.p_irq !== 1'b1) begin bad++; $display("FAIL r4_irq got=%b want=1", bus.p_irq); end
      wr(3, 8'h99);
      rd(3, d);
      total++; if (d !== 8'h88) begin bad++; $display("FAIL r4_keep got=%h want=88", d); end
      total++; if (bus.p_irq !== 1'b0) begin bad++; $display("FAIL r4_irq_clr got=%b want=0", bus.p_irq); end
      bus.irq_en_r4 = 1'b0;
   endtask

   task automatic test_mode_flush();
      logic [7:0] d;
      bus.one_byte_mode = 1'b0;
      tick();
      wr(2, 8'h5A);
      bus.one_byte_mode = 1'b1;
      tick();
      total++; if (bus.p_data_available[2] !== 1'b0) begin bad++; $display("FAIL flush_avail got=%b want=0", bus.p_data_available[2]); end
      total++; if (bus.h_full[2] !== 1'b0) begin bad++; $display("FAIL flush_full got=%b want=0", bus.h_full[2]); end
      wr(2, 8'h77);
      rd(2, d);
      total++; if (d !== 8'h77) begin bad++; $display("FAIL flush_fresh got=%h want=77", d); end
      // Write landing on the flush edge is discarded.
      bus.h_we          = 1'b1;
      bus.h_selectData  = 4'b0100;
      bus.h_data        = 8'hEE;
      bus.one_byte_mode = 1'b0;
      tick();
      idle();
      wr(2, 8'h12);
      total++; if (bus.p_data_available[2] !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", bus.p_data_available[2]); end
      wr(2, 8'h34);
      rd(2, d);
      total++; if (d !== 8'h12) begin bad++; $display("FAIL flush_order got=%h want=12", d); end
      rd(2, d);
      total++; if (d !== 8'h34) begin bad++; $display("FAIL flush_second got=%h want=34", d); end
   endtask

   task automatic test_random();
      logic [3:0] exp_av;
      logic [3:0] exp_fu;
      logic       exp_irq;
      logic       exp_nmi;
      logic [7:0] exp_pd;
      bit         chk_pd;
      bit         flush;
      bit         pop;
      bit         push;
      logic       prev_mode;
      int         wi;
      int         ri;
      int         si;

      idle();
      bus.one_byte_mode = 1'($urandom_range(0, 1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prev_mode = bus.one_byte_mode;
      for (int i = 0; i < 4; i++) mq[i].delete();

      for (int n = 0; n < 400; n++) begin
         bus.h_we         = 1'($urandom_range(0, 1));
         bus.h_selectData = 4'($urandom_range(0, 15));
         bus.h_data       = 8'($urandom());
         bus.p_rd         = 1'($urandom_range(0, 1));
         bus.p_selectData = 4'($urandom_range(0, 15));
         bus.irq_en_r1    = 1'($urandom_range(0, 1));
         bus.irq_en_r4    = 1'($urandom_range(0, 1));
         bus.nmi_en       = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 24) == 0) bus.one_byte_mode = ~bus.one_byte_mode;
         @(negedge clk);

         for (int i = 0; i < 4; i++) begin
            if (i == 2) exp_av[i] = bus.one_byte_mode ? (mq[i].size() >= 1) : (mq[i].size() == 2);
            else        exp_av[i] = (mq[i].size() != 0);
         end
         exp_fu  = exp_av;
         exp_irq = (bus.irq_en_r1 & exp_av[0]) | (bus.irq_en_r4 & exp_av[3]);
         exp_nmi = bus.nmi_en & exp_av[2];
         si = lowest(bus.p_selectData);
         chk_pd = 1'b1;
         exp_pd = 8'h00;
         if (si >= 0) begin
            if (mq[si].size() != 0) exp_pd = mq[si][0];
            else chk_pd = 1'b0;
         end

         total++; if (bus.p_data_available !== exp_av) begin bad++; $display("FAIL rnd_avail cyc=%0d got=%b want=%b", n, bus.p_data_available, exp_av); end
         total++; if (bus.h_full !== exp_fu) begin bad++; $display("FAIL rnd_full cyc=%0d got=%b want=%b", n, bus.h_full, exp_fu); end
         total++; if (bus.p_irq !== exp_irq) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%b want=%b", n, bus.p_irq, exp_irq); end
         total++; if (bus.p_nmi !== exp_nmi) begin bad++; $display("FAIL rnd_nmi cyc=%0d got=%b want=%b", n, bus.p_nmi, exp_nmi); end
         if (chk_pd) begin
            total++; if (bus.p_data !== exp_pd) begin bad++; $display("FAIL rnd_pdata cyc=%0d got=%h want=%h", n, bus.p_data, exp_pd); end
         end

         flush     = (bus.one_byte_mode != prev_mode);
         prev_mode = bus.one_byte_mode;
         wi = bus.h_we ? lowest(bus.h_selectData) : -1;
         ri = bus.p_rd ? lowest(bus.p_selectData) : -1;
         for (int i = 0; i < 4; i++) begin
            if (i == 2 && flush) begin
               mq[i].delete();
            end else begin
               pop  = (ri == i) && (mq[i].size() != 0);
               push = (wi == i) && (!exp_fu[i] || pop);
               if (pop)  void'(mq[i].pop_front());
               if (push) mq[i].push_back(bus.h_data);
            end
         end
         tick();
      end
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      bus.h_data = 8'h00;
      test_reset();
      test_r1_irq();
      test_r3_two_byte();
      test_r3_one_byte();
      test_collide();
      test_mode_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
